// File: rtl/leg_lite_pkg.sv
// Shared constants for the LEGLite single-cycle core: opcodes, instruction
// field positions and the zero-register index.
package leg_lite_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_LDUR = 3'b100;
    localparam logic [2:0] OP_STUR = 3'b101;
    localparam logic [2:0] OP_CBZ  = 3'b110;
    localparam logic [2:0] OP_B    = 3'b111;

    localparam int F_OP_HI    = 15;
    localparam int F_OP_LO    = 13;
    localparam int F_RM_HI    = 12;
    localparam int F_RM_LO    = 10;
    localparam int F_IMM7_HI  = 12;
    localparam int F_IMM7_LO  = 6;
    localparam int F_RN_HI    = 5;
    localparam int F_RN_LO    = 3;
    localparam int F_RT_HI    = 2;
    localparam int F_RT_LO    = 0;
    localparam int F_IMM13_HI = 12;

    localparam logic [2:0] XZR = 3'd7;

    // Branch offsets are in halfwords; scale to a byte offset.
    function automatic logic [15:0] sext7_x2(input logic [6:0] v);
        return {{8{v[6]}}, v, 1'b0};
    endfunction

    function automatic logic [15:0] sext13_x2(input logic [12:0] v);
        return {{2{v[12]}}, v, 1'b0};
    endfunction

endpackage

// File: rtl/leg_lite_if.sv
// Instruction-fetch and data-memory bus between the core (master) and the
// external ROM / data memory / I/O block (slave).
interface leg_lite_if;
    logic [15:0] iaddr;
    logic [15:0] idata;
    logic [15:0] draddr;
    logic [15:0] drdata;
    logic [15:0] dwdata;
    logic [15:0] alu_out;
    logic        dwrite;
    logic        dread;

    modport master (
        output iaddr, draddr, dwrite, dread, dwdata, alu_out,
        input  idata, drdata
    );

    modport slave (
        input  iaddr, draddr, dwrite, dread, dwdata, alu_out,
        output idata, drdata
    );
endinterface

// File: rtl/leg_lite_regfile.sv
// 8 x 16 register file: two asynchronous read ports, one synchronous write
// port, synchronous reset. Index 7 is the zero register.
module leg_lite_regfile
    import leg_lite_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  raddr_a,
    input  logic [2:0]  raddr_b,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata
);

    logic [15:0] regs [0:7];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we && (waddr != XZR)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == XZR) ? 16'h0000 : regs[raddr_a];
    assign rdata_b = (raddr_b == XZR) ? 16'h0000 : regs[raddr_b];

endmodule

// File: rtl/leg_lite_single.sv
// Single-cycle 16-bit LEGLite core: fetch, decode, execute, memory access and
// writeback all complete within one clock; state is the PC and register file.
module leg_lite_single
    import leg_lite_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    leg_lite_if.master  bus
);

    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [2:0]  op;
    logic [2:0]  rm;
    logic [2:0]  rn;
    logic [2:0]  rt;
    logic [6:0]  imm7;
    logic [12:0] imm13;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic [15:0] alu;
    logic [15:0] wdata;
    logic        reg_we;

    assign op    = bus.idata[F_OP_HI:F_OP_LO];
    assign rm    = bus.idata[F_RM_HI:F_RM_LO];
    assign imm7  = bus.idata[F_IMM7_HI:F_IMM7_LO];
    assign rn    = bus.idata[F_RN_HI:F_RN_LO];
    assign rt    = bus.idata[F_RT_HI:F_RT_LO];
    assign imm13 = bus.idata[F_IMM13_HI:0];

    // Port B reads rm for register-register ops, otherwise rt (store data / CBZ test).
    assign raddr_b = (op == OP_ADD || op == OP_SUB || op == OP_AND) ? rm : rt;

    leg_lite_regfile u_regfile (
        .clock   (clock),
        .reset   (reset),
        .raddr_a (rn),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (reg_we),
        .waddr   (rt),
        .wdata   (wdata)
    );

    always_comb begin
        alu = rdata_b;
        case (op)
            OP_ADD:  alu = rdata_a + rdata_b;
            OP_SUB:  alu = rdata_a - rdata_b;
            OP_AND:  alu = rdata_a & rdata_b;
            OP_ADDI: alu = rdata_a + {9'b0, imm7};
            OP_LDUR,
            OP_STUR: alu = rdata_a + {{9{imm7[6]}}, imm7};
            default: alu = rdata_b;
        endcase
    end

    assign reg_we = !reset && (op == OP_ADD || op == OP_SUB || op == OP_AND ||
                               op == OP_ADDI || op == OP_LDUR);
    assign wdata  = (op == OP_LDUR) ? bus.drdata : alu;

    always_comb begin
        pc_next = pc + 16'd2;
        if (op == OP_B)
            pc_next = pc + sext13_x2(imm13);
        else if (op == OP_CBZ && rdata_b == 16'h0000)
            pc_next = pc + sext7_x2(imm7);
    end

    always_ff @(posedge clock) begin
        if (reset) pc <= '0;
        else       pc <= pc_next;
    end

    assign bus.iaddr   = pc;
    assign bus.alu_out = alu;
    assign bus.draddr  = alu;
    assign bus.dwdata  = rdata_b;
    assign bus.dread   = (op == OP_LDUR);
    assign bus.dwrite  = (op == OP_STUR) && !reset;

endmodule

// File: tb/tb_leg_lite_single.sv
// Directed program bench for leg_lite_single with a small ROM and data memory.
module tb_leg_lite_single;

    logic clock;
    logic reset;
    logic override_en;
    logic [15:0] override_word;
    logic [15:0] rom  [0:31];
    logic [15:0] dmem [0:15];
    int checks;
    int errors;
    int store_cnt;

    leg_lite_if bus ();

    leg_lite_single dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.idata  = override_en ? override_word : rom[bus.iaddr[5:1]];
    assign bus.drdata = dmem[bus.draddr[4:1]];

    always @(posedge clock) begin
        if (bus.dwrite) begin
            dmem[bus.draddr[4:1]] <= bus.dwdata;
            store_cnt <= store_cnt + 1;
        end
    end

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rm,
                                          input logic [2:0] rn, input logic [2:0] rd);
        return {op, rm, 4'b0000, rn, rd};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [6:0] imm,
                                          input logic [2:0] rn, input logic [2:0] rt);
        return {op, imm, rn, rt};
    endfunction

    function automatic logic [15:0] enc_b(input logic [12:0] imm);
        return {3'b111, imm};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        store_cnt = 0;
        override_en = 1'b0;
        override_word = '0;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 16; i++) dmem[i] = 16'h0000;
        rom[0]  = enc_i(3'b011, 7'd3,    3'd7, 3'd4);  // ADDI X4,XZR,#3
        rom[1]  = enc_i(3'b011, 7'd3,    3'd4, 3'd4);  // ADDI X4,X4,#3
        rom[2]  = enc_r(3'b000, 3'd4,    3'd4, 3'd5);  // ADD  X5,X4,X4
        rom[3]  = enc_r(3'b001, 3'd4,    3'd7, 3'd1);  // SUB  X1,XZR,X4
        rom[4]  = enc_i(3'b011, 7'd15,   3'd7, 3'd3);  // ADDI X3,XZR,#15
        rom[5]  = enc_r(3'b010, 3'd3,    3'd1, 3'd1);  // AND  X1,X1,X3
        rom[6]  = enc_i(3'b101, 7'd8,    3'd7, 3'd4);  // STUR X4,[XZR,#8]
        rom[7]  = enc_i(3'b100, 7'd8,    3'd7, 3'd2);  // LDUR X2,[XZR,#8]
        rom[8]  = enc_r(3'b000, 3'd5,    3'd2, 3'd6);  // ADD  X6,X2,X5
        rom[9]  = enc_i(3'b011, 7'h7F,   3'd7, 3'd0);  // ADDI X0,XZR,#127
        rom[10] = enc_i(3'b110, 7'd5,    3'd0, 3'd4);  // CBZ  X4,#5
        rom[11] = enc_i(3'b011, 7'd5,    3'd7, 3'd7);  // ADDI X7,XZR,#5
        rom[12] = enc_r(3'b000, 3'd7,    3'd7, 3'd1);  // ADD  X1,X7,X7
        rom[13] = enc_r(3'b001, 3'd5,    3'd0, 3'd0);  // SUB  X0,X0,X5
        rom[14] = enc_i(3'b101, 7'h7E,   3'd4, 3'd5);  // STUR X5,[X4,#-2]
        rom[15] = enc_b(13'd2);                         // B    #2
        rom[16] = enc_b(13'd0);                         // B    #0
        rom[17] = enc_i(3'b110, 7'h7F,   3'd0, 3'd7);  // CBZ  XZR,#-1

        reset = 1'b1;
        @(negedge clock);
        step();
        check_val("rst_pc", bus.iaddr, 16'h0000);
        check_val("rst_dwrite", {15'b0, bus.dwrite}, 16'h0000);
        reset = 1'b0;
        #1;
        check_val("pc0", bus.iaddr, 16'h0000);
        check_val("addi_xzr", bus.alu_out, 16'h0003);
        step();
        check_val("pc2", bus.iaddr, 16'h0002);
        check_val("addi_x4", bus.alu_out, 16'h0006);
        step();
        check_val("pc4", bus.iaddr, 16'h0004);
        check_val("add_x5", bus.alu_out, 16'h000C);
        step();
        check_val("pc6", bus.iaddr, 16'h0006);
        check_val("sub_neg", bus.alu_out, 16'hFFFA);
        step();
        check_val("addi_15", bus.alu_out, 16'h000F);
        step();
        check_val("and_mask", bus.alu_out, 16'h000A);
        step();
        check_val("stur_dwrite", {15'b0, bus.dwrite}, 16'h0001);
        check_val("stur_dread", {15'b0, bus.dread}, 16'h0000);
        check_val("stur_addr", bus.draddr, 16'h0008);
        check_val("stur_data", bus.dwdata, 16'h0006);
        step();
        check_val("ldur_dread", {15'b0, bus.dread}, 16'h0001);
        check_val("ldur_dwrite", {15'b0, bus.dwrite}, 16'h0000);
        check_val("ldur_addr", bus.draddr, 16'h0008);
        step();
        check_val("ldur_result", bus.alu_out, 16'h0012);
        step();
        check_val("addi_zext", bus.alu_out, 16'h007F);
        step();
        check_val("cbz_pc", bus.iaddr, 16'h0014);
        step();
        check_val("cbz_not_taken", bus.iaddr, 16'h0016);
        check_val("addi_x7", bus.alu_out, 16'h0005);
        step();
        check_val("xzr_read", bus.alu_out, 16'h0000);
        step();
        check_val("sub_x0", bus.alu_out, 16'h0073);
        step();
        check_val("stur_neg_addr", bus.draddr, 16'h0004);
        check_val("stur_neg_data", bus.dwdata, 16'h000C);
        step();
        check_val("b_pc", bus.iaddr, 16'h001E);
        step();
        check_val("b_fwd", bus.iaddr, 16'h0022);
        step();
        check_val("cbz_xzr_back", bus.iaddr, 16'h0020);
        step();
        check_val("b_self_1", bus.iaddr, 16'h0020);
        step();
        check_val("b_self_2", bus.iaddr, 16'h0020);
        check_val("store_cnt", 16'(store_cnt), 16'd2);
        check_val("mem_8", dmem[4], 16'h0006);
        check_val("mem_4", dmem[2], 16'h000C);

        override_en = 1'b1;
        override_word = enc_i(3'b101, 7'd8, 3'd7, 3'd4);  // STUR under reset
        reset = 1'b1;
        #1;
        check_val("rst_stur_dwrite", {15'b0, bus.dwrite}, 16'h0000);
        step();
        check_val("rst_mid_pc", bus.iaddr, 16'h0000);
        check_val("rst_no_store", 16'(store_cnt), 16'd2);
        reset = 1'b0;
        override_word = enc_r(3'b000, 3'd5, 3'd4, 3'd0);  // ADD X0,X4,X5
        #1;
        check_val("rst_regs_a", bus.alu_out, 16'h0000);
        step();
        check_val("rst_resume", bus.iaddr, 16'h0002);
        override_word = enc_r(3'b000, 3'd6, 3'd2, 3'd1);  // ADD X1,X2,X6
        #1;
        check_val("rst_regs_b", bus.alu_out, 16'h0000);
        step();
        override_word = enc_b(13'h1FFD);                    // B #-3
        #1;
        check_val("pc_before_wrap", bus.iaddr, 16'h0004);
        step();
        check_val("b_neg", bus.iaddr, 16'hFFFE);
        override_word = enc_i(3'b011, 7'd1, 3'd7, 3'd1);
        step();
        check_val("pc_wrap", bus.iaddr, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
